// File: rtl/fifo_rd_unpacker_pkg.sv
// Shared constants and helpers for the FIFO read-side unpacker.
// Signal levels, statistics counter width, sub-index sizing and a saturating increment.
package fifo_rd_unpacker_pkg;

    localparam logic SIG_HIGH = 1'b1;
    localparam logic SIG_LOW  = 1'b0;

    localparam int STAT_W = 32;

    // Width of the sub-word index; a single-slice word still needs one bit.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_unpacker_prefetch.sv
// Prefetch stage for the FIFO read port: read credit, rdena and a 2-entry word buffer.
// The head entry is the word being unpacked; the tail entry holds the prefetched word.
module fifo_rd_unpacker_prefetch
    import fifo_rd_unpacker_pkg::*;
#(
    parameter int p_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_empty,
    input  logic [p_WIDTH-1:0] fifo_rddata,
    input  logic               pop,
    output logic               fifo_rdena,
    output logic               headValid,
    output logic [p_WIDTH-1:0] headData,
    output logic               tailValid,
    output logic               inFlight
);

    logic               headValid_q, headValid_d;
    logic               tailValid_q, tailValid_d;
    logic               inFlight_q,  inFlight_d;
    logic [p_WIDTH-1:0] head_q, head_d;
    logic [p_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]         occupancy;

    // Issue a read only if the word can be guaranteed a slot; a head retiring this cycle frees its slot now,
    // which is what lets a one-slice word stream at one word per clock.
    always_comb begin
        occupancy  = {1'b0, headValid_q} + {1'b0, tailValid_q} + {1'b0, inFlight_q} - {1'b0, pop};
        fifo_rdena = SIG_LOW;
        if (!rst && !fifo_empty && (occupancy < 2'd2)) begin
            fifo_rdena = SIG_HIGH;
        end
    end

    // Buffer update: the arriving word lands in the first free slot, and on a head retire the tail
    // (or the arriving word directly) slides into the head so no bubble appears.
    always_comb begin
        headValid_d = headValid_q;
        tailValid_d = tailValid_q;
        head_d      = head_q;
        tail_d      = tail_q;
        inFlight_d  = fifo_rdena;
        if (pop) begin
            if (tailValid_q) begin
                head_d = tail_q;
                if (inFlight_q) begin
                    tail_d = fifo_rddata;
                end else begin
                    tailValid_d = SIG_LOW;
                end
            end else if (inFlight_q) begin
                head_d = fifo_rddata;
            end else begin
                headValid_d = SIG_LOW;
            end
        end else if (inFlight_q) begin
            if (!headValid_q) begin
                headValid_d = SIG_HIGH;
                head_d      = fifo_rddata;
            end else begin
                tailValid_d = SIG_HIGH;
                tail_d      = fifo_rddata;
            end
        end
    end

    // State register; reset drops buffered words and forgets any outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            headValid_q <= SIG_LOW;
            tailValid_q <= SIG_LOW;
            inFlight_q  <= SIG_LOW;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            headValid_q <= headValid_d;
            tailValid_q <= tailValid_d;
            inFlight_q  <= inFlight_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    assign headValid = headValid_q;
    assign headData  = head_q;
    assign tailValid = tailValid_q;
    assign inFlight  = inFlight_q;

endmodule

// File: rtl/fifo_rd_unpacker.sv
// Drains p_WIDTH-bit FIFO words and emits them as p_OUT_WIDTH-bit sub-words on a valid/ready stream.
// Optional build macro FIFO_RD_UNPACKER_STATS_EN adds saturating stat_words / stat_stall counters.
module fifo_rd_unpacker
    import fifo_rd_unpacker_pkg::*;
#(
    parameter int p_WIDTH     = 32,
    parameter int p_OUT_WIDTH = 8,
    parameter int p_LSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_rdena,
    input  logic [p_WIDTH-1:0]     fifo_rddata,
    output logic [p_OUT_WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
`ifdef FIFO_RD_UNPACKER_STATS_EN
    ,
    output logic [STAT_W-1:0]      stat_words,
    output logic [STAT_W-1:0]      stat_stall
`endif
);

    localparam int lp_RATIO = p_WIDTH / p_OUT_WIDTH;
    localparam int IDX_W    = idx_width(lp_RATIO);

    logic               headValid;
    logic               tailValid;
    logic               inFlight;
    logic [p_WIDTH-1:0] headData;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               isLast;
    logic               xfer;
    logic               pop;
    int                 sel;

    fifo_rd_unpacker_prefetch #(
        .p_WIDTH (p_WIDTH)
    ) u_prefetch (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rddata (fifo_rddata),
        .pop         (pop),
        .fifo_rdena  (fifo_rdena),
        .headValid   (headValid),
        .headData    (headData),
        .tailValid   (tailValid),
        .inFlight    (inFlight)
    );

    // Handshake and slice selection; everything follows the head word and the index, so a stalled
    // output keeps data and last stable until it is accepted.
    always_comb begin
        isLast    = (idx_q == IDX_W'(lp_RATIO - 1));
        out_valid = headValid;
        out_last  = headValid & isLast;
        xfer      = headValid & out_ready;
        pop       = xfer & isLast;
        busy      = headValid | tailValid | inFlight;
        sel       = (p_LSB_FIRST != 0) ? int'(idx_q) : (lp_RATIO - 1 - int'(idx_q));
        out_data  = headData[sel*p_OUT_WIDTH +: p_OUT_WIDTH];
    end

    // Sub-word index advances on each accepted slice and wraps when the word retires.
    always_comb begin
        idx_d = idx_q;
        if (xfer) begin
            idx_d = isLast ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

`ifdef FIFO_RD_UNPACKER_STATS_EN
    logic [STAT_W-1:0] statWords_q;
    logic [STAT_W-1:0] statStall_q;

    // Count retired words and stalled output cycles, both pinned at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            statWords_q <= '0;
            statStall_q <= '0;
        end else begin
            if (pop) begin
                statWords_q <= sat_inc(statWords_q);
            end
            if (headValid && !out_ready) begin
                statStall_q <= sat_inc(statStall_q);
            end
        end
    end

    assign stat_words = statWords_q;
    assign stat_stall = statStall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: byte unpacking instance (32->8, LSB first) plus a one-slice instance (32->32).
// A queue model of the expected sub-word stream is checked every cycle; directed scenarios add literal checks.
module tb_fifo_rd_unpacker;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        outReady = 1'b1;
    logic        fifoEmpty, rdena, outValid, outLast, busy;
    logic [31:0] rdData = '0;
    logic [7:0]  outData;

    logic        fifoEmpty1, rdena1, outValid1, outLast1, busy1;
    logic [31:0] rdData1 = '0;
    logic [31:0] outData1;

`ifdef FIFO_RD_UNPACKER_STATS_EN
    logic [31:0] statWords, statStall, statWords1, statStall1;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] fifoMem  [0:2047];
    logic [31:0] fifo1Mem [0:63];
    int wrPtr = 0, rdPtr = 0, wr1Ptr = 0, rd1Ptr = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } sub_t;
    sub_t expQ[$];
    int   cyc = 0;
    int   xferCount = 0;

    always #5 clk = ~clk;

    assign fifoEmpty  = (rdPtr == wrPtr);
    assign fifoEmpty1 = (rd1Ptr == wr1Ptr);

    fifo_rd_unpacker #(.p_WIDTH(32), .p_OUT_WIDTH(8), .p_LSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifoEmpty), .fifo_rdena(rdena), .fifo_rddata(rdData),
        .out_data(outData), .out_valid(outValid), .out_ready(outReady), .out_last(outLast), .busy(busy)
`ifdef FIFO_RD_UNPACKER_STATS_EN
        , .stat_words(statWords), .stat_stall(statStall)
`endif
    );

    fifo_rd_unpacker #(.p_WIDTH(32), .p_OUT_WIDTH(32), .p_LSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(fifoEmpty1), .fifo_rdena(rdena1), .fifo_rddata(rdData1),
        .out_data(outData1), .out_valid(outValid1), .out_ready(1'b1), .out_last(outLast1), .busy(busy1)
`ifdef FIFO_RD_UNPACKER_STATS_EN
        , .stat_words(statWords1), .stat_stall(statStall1)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic readyV, input int n);
        rst      = rstV;
        outReady = readyV;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [31:0] w);
        fifoMem[wrPtr] = w;
        wrPtr++;
    endtask

    task automatic waitIdle(input string name, input int maxCycles);
        int i;
        for (i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (!busy && fifoEmpty) break;
        end
        if (i == maxCycles) checkOutput(name, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Synchronous FIFO read port model: data appears one clock after rdena.
    always @(posedge clk) begin
        if (rdena && (rdPtr != wrPtr)) begin
            rdData <= fifoMem[rdPtr];
            rdPtr  <= rdPtr + 1;
        end
        if (rdena1 && (rd1Ptr != wr1Ptr)) begin
            rdData1 <= fifo1Mem[rd1Ptr];
            rd1Ptr  <= rd1Ptr + 1;
        end
    end

    // Model: every word read expands into R sub-words (LSB first, last on the final one); the front
    // sub-word is presentable two cycles after its word was read, and reads need fewer than 2 words held.
    always @(negedge clk) begin
        int          outstanding;
        logic        expValid;
        logic        retire;
        logic        expRd;
        logic [31:0] w;
        sub_t        e;
        cyc = cyc + 1;
        if (rst) begin
            expQ.delete();
        end else begin
            expValid = (expQ.size() > 0) && (expQ[0].cyc + 2 <= cyc);
            checkOutput("out_valid", outValid, expValid);
            checkOutput("busy", busy, expQ.size() != 0);
            if (expValid) begin
                checkOutput("out_data", outData, expQ[0].data);
                checkOutput("out_last", outLast, expQ[0].last);
            end else begin
                checkOutput("out_last_idle", outLast, 32'd0);
            end
            outstanding = 0;
            foreach (expQ[i]) if (expQ[i].last) outstanding++;
            retire = expValid && outReady && expQ[0].last;
            expRd  = (rdPtr != wrPtr) && ((outstanding - int'(retire)) < 2);
            checkOutput("fifo_rdena", rdena, expRd);
            if (expValid && outReady) begin
                void'(expQ.pop_front());
                xferCount = xferCount + 1;
            end
            if (rdena && (rdPtr != wrPtr)) begin
                w = fifoMem[rdPtr];
                for (int k = 0; k < R; k++) begin
                    e.data = w[8*k +: 8];
                    e.last = (k == R - 1);
                    e.cyc  = cyc;
                    expQ.push_back(e);
                end
            end
        end
    end

    // Hard stop so the run can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios.
    initial begin
        int          rdCyc, vFirst, vLast, n, rdCount, base, i;
        logic [7:0]  got [0:7];
        logic        gotLast [0:7];
        logic [31:0] w6;

        // Reset held with a non-empty FIFO: nothing may be read or presented.
        pushWord(32'h44332211);
        rst = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("reset_rdena", rdena, 32'd0);
            checkOutput("reset_valid", outValid, 32'd0);
            checkOutput("reset_busy", busy, 32'd0);
            checkOutput("reset_data", outData, 32'd0);
        end
        @(posedge clk);
        #1;

        // Single word, sink always ready.
        applyStimulus(1'b0, 1'b1, 0);
        rdCyc = -1; vFirst = -1; vLast = -1; n = 0; rdCount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rdena) begin
                rdCount++;
                if (rdCyc < 0) rdCyc = c;
            end
            if (outValid) begin
                if (n < 8) begin
                    got[n]     = outData;
                    gotLast[n] = outLast;
                end
                if (vFirst < 0) vFirst = c;
                vLast = c;
                n++;
            end
        end
        checkOutput("single_count", n, 4);
        checkOutput("single_rdena_pulses", rdCount, 1);
        checkOutput("single_latency", vFirst - rdCyc, 2);
        checkOutput("single_back_to_back", vLast - vFirst, 3);
        checkOutput("single_b0", got[0], 8'h11);
        checkOutput("single_b1", got[1], 8'h22);
        checkOutput("single_b2", got[2], 8'h33);
        checkOutput("single_b3", got[3], 8'h44);
        checkOutput("single_last0", gotLast[0], 0);
        checkOutput("single_last1", gotLast[1], 0);
        checkOutput("single_last2", gotLast[2], 0);
        checkOutput("single_last3", gotLast[3], 1);

        // Backpressure: sink stalled, three words available; only two may be fetched.
        @(posedge clk);
        #1;
        outReady = 1'b0;
        pushWord(32'h87654321);
        pushWord(32'h0F0E0D0C);
        pushWord(32'h1B1A1918);
        rdCount = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdena) rdCount++;
        end
        checkOutput("bp_rdena_pulses", rdCount, 2);
        checkOutput("bp_valid", outValid, 1);
        checkOutput("bp_data_first", outData, 8'h21);
        checkOutput("bp_last_first", outLast, 0);
        @(posedge clk);
        #1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rdena) rdCount++;
            checkOutput("bp_hold_data", outData, 8'h43);
            checkOutput("bp_hold_last", outLast, 0);
        end
        checkOutput("bp_rdena_total", rdCount, 2);
        @(posedge clk);
        #1;
        outReady = 1'b1;
        waitIdle("bp_drain_timeout", 100);

        // Long stream with a randomly stalling sink.
        base = xferCount;
        for (int k = 0; k < 1000; k++) pushWord(32'h0000_1000 + k);
        for (i = 0; i < 20000; i++) begin
            outReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!busy && fifoEmpty) break;
            @(posedge clk);
            #1;
        end
        if (i == 20000) checkOutput("stream_timeout", 32'd0, 32'd1);
        checkOutput("stream_subwords", xferCount - base, 4000);
        @(posedge clk);
        #1;
        outReady = 1'b1;

        // Reset while one word is buffered and another is in flight.
        outReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w6 = {8'h40 + 8'(k), 8'h30 + 8'(k), 8'h20 + 8'(k), 8'h10 + 8'(k)};
            pushWord(w6);
        end
        applyStimulus(1'b0, 1'b0, 2);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_rdena", rdena, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_valid", outValid, 32'd0);
        checkOutput("post_reset_busy", busy, 32'd0);
`ifdef FIFO_RD_UNPACKER_STATS_EN
        checkOutput("post_reset_stat_words", statWords, 32'd0);
`endif
        @(posedge clk);
        #1;
        outReady = 1'b1;
        n = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (outValid) begin
                n = 32'(outData);
                break;
            end
        end
        checkOutput("post_reset_first", n, 32'h12);
        @(posedge clk);
        #1;
        waitIdle("post_reset_drain_timeout", 100);

        // One slice per word: sixteen words must stream on sixteen consecutive clocks.
        for (int k = 0; k < 16; k++) begin
            fifo1Mem[wr1Ptr] = 32'hC0DE_0000 + k;
            wr1Ptr++;
        end
        n = 0; vFirst = -1; vLast = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (outValid1) begin
                if (n < 16) begin
                    checkOutput("r1_data", outData1, 32'hC0DE_0000 + n);
                    checkOutput("r1_last", outLast1, 1);
                end
                if (vFirst < 0) vFirst = c;
                vLast = c;
                n++;
            end
        end
        checkOutput("r1_count", n, 16);
        checkOutput("r1_consecutive", vLast - vFirst, 15);
        checkOutput("r1_idle_busy", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
